// File: rtl/seg7_pkg.sv
// Shared types and seven-segment encoding for the random-value display.
package seg7_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam int BCD_W = 12;

    // Active-low segments, bit6=g .. bit0=a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_random_display_if.sv
// Value-in / digits-out bundle between the random generator and the display stage.
interface seg7_random_display_if #(parameter int IN_W = 7);
    logic [IN_W-1:0] i_value;
    logic            i_enable;
    logic [6:0]      o_hex0;
    logic [6:0]      o_hex1;
    logic [6:0]      o_hex2;
    logic            o_busy;
    logic            o_update;

    modport master (output i_value, i_enable,
                    input  o_hex0, o_hex1, o_hex2, o_busy, o_update);
    modport slave  (input  i_value, i_enable,
                    output o_hex0, o_hex1, o_hex2, o_busy, o_update);
endinterface

// File: rtl/seg7_random_display_bin2bcd.sv
// Sequential double-dabble: one input bit per i_step cycle, IN_W steps per conversion.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int IN_W = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [IN_W-1:0]  i_bin,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);
    localparam int            CW   = $clog2(IN_W);
    localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

    logic [IN_W-1:0]  shift_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj;
    logic [CW-1:0]    cnt_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else if (i_start) begin
            shift_q <= i_bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else if (i_step) begin
            // Hundreds nibble never exceeds 1, so the bit shifted out the top is always 0
            {bcd_q, shift_q} <= {adj, shift_q} << 1;
            cnt_q            <= cnt_q + 1'b1;
        end
    end

    assign o_done = i_step && (cnt_q == LAST);
    assign o_bcd  = bcd_q;

endmodule

// File: rtl/seg7_random_display.sv
// Converts the generator's random value to three active-low decimal digits,
// reconverting whenever the input differs from the last converted value.
module seg7_random_display
    import seg7_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1,
    parameter int IN_W     = 7
) (
    input logic                  i_clk,
    input logic                  i_rst,
    seg7_random_display_if.slave bus
);
    state_t           state_q, state_d;
    logic             have_q;
    logic [IN_W-1:0]  last_q;
    logic [BCD_W-1:0] dig_q;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] disp;
    logic [6:0]       hex0_q, hex1_q, hex2_q;
    logic [6:0]       seg0, seg1, seg2;
    logic             start, done, lz2, lz1;

    assign start = (state_q == IDLE) && (!have_q || (bus.i_value != last_q));

    bin2bcd_seq #(.IN_W(IN_W)) u_bcd (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (start),
        .i_step  (state_q == SHIFT),
        .i_bin   (bus.i_value),
        .o_done  (done),
        .o_bcd   (bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (done)  state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Fresh result bypasses dig_q so digits appear the cycle after LATCH
    assign disp = (state_q == LATCH) ? bcd : dig_q;
    assign lz2  = BLANK_LZ && (disp[11:8] == 4'd0);
    assign lz1  = lz2 && (disp[7:4] == 4'd0);
    assign seg2 = lz2 ? SEG_BLANK : bcd_to_seg(disp[11:8]);
    assign seg1 = lz1 ? SEG_BLANK : bcd_to_seg(disp[7:4]);
    assign seg0 = bcd_to_seg(disp[3:0]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            have_q <= 1'b0;
            last_q <= '0;
            dig_q  <= '0;
            hex0_q <= SEG_BLANK;
            hex1_q <= SEG_BLANK;
            hex2_q <= SEG_BLANK;
        end else begin
            if (start) last_q <= bus.i_value;
            if (state_q == LATCH) begin
                have_q <= 1'b1;
                dig_q  <= bcd;
            end
            hex0_q <= bus.i_enable ? seg0 : SEG_BLANK;
            hex1_q <= bus.i_enable ? seg1 : SEG_BLANK;
            hex2_q <= bus.i_enable ? seg2 : SEG_BLANK;
        end
    end

    assign bus.o_hex0   = hex0_q;
    assign bus.o_hex1   = hex1_q;
    assign bus.o_hex2   = hex2_q;
    assign bus.o_busy   = (state_q != IDLE);
    assign bus.o_update = (state_q == LATCH);

endmodule

// File: tb/tb_seg7_random_display.sv
// Directed vectors for seg7_random_display; expected digits and update cycle go
// through a scoreboard queue checked by a monitor on each o_update pulse.
module tb_seg7_random_display;

    typedef struct {
        string       nm;
        logic [20:0] hex;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   errors  = 0;
    exp_t sb[$];

    seg7_random_display_if #(.IN_W(7)) bus ();

    seg7_random_display #(.BLANK_LZ(1'b1), .IN_W(7)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [20:0] pk(input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
        return {h2, h1, h0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input string nm, input logic [6:0] v, input logic [20:0] h);
        exp_t e;
        bus.i_value = v;
        e.nm  = nm;
        e.hex = h;
        e.cyc = cyc + 8;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.o_busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout: %0d entries still pending", nm, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: o_update seen -> check its cycle, then the digits one cycle later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_update === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_update: got pulse at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, "_upd_cyc"}, cyc, e.cyc);
                    @(negedge clk);
                    chk({e.nm, "_hex"}, {11'b0, bus.o_hex2, bus.o_hex1, bus.o_hex0}, {11'b0, e.hex});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bc, uc;
        rst          = 1'b1;
        bus.i_value  = 7'd0;
        bus.i_enable = 1'b1;
        @(negedge clk);
        chk("rst_hex", {11'b0, bus.o_hex2, bus.o_hex1, bus.o_hex0}, {11'b0, pk(7'h7F, 7'h7F, 7'h7F)});
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_update", bus.o_update, 0);
        @(negedge clk);

        // First post-reset cycle always converts, even for value 0
        rst = 1'b0;
        drive("v0", 7'd0, pk(7'h7F, 7'h7F, 7'h40));
        wait_done("v0");

        drive("v57", 7'd57, pk(7'h7F, 7'h12, 7'h78));
        bc = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_busy) bc++;
        end
        chk("v57_busy_cycles", bc, 8);
        wait_done("v57");

        drive("v100", 7'd100, pk(7'h79, 7'h40, 7'h40));
        wait_done("v100");
        drive("v127", 7'd127, pk(7'h79, 7'h24, 7'h78));
        wait_done("v127");

        // Change during SHIFT: 42 shown first, then automatic reconversion to 9
        drive("v42", 7'd42, pk(7'h7F, 7'h19, 7'h24));
        uc = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (bus.o_update) uc++;
            if (k == 3) begin
                bus.i_value = 7'd9;
                begin
                    exp_t e;
                    e.nm  = "v9";
                    e.hex = pk(7'h7F, 7'h7F, 7'h10);
                    e.cyc = cyc - 3 + 17;
                    sb.push_back(e);
                end
            end
        end
        chk("v42_9_update_count", uc, 2);
        wait_done("v9");

        drive("v33", 7'd33, pk(7'h7F, 7'h30, 7'h30));
        wait_done("v33");
        bus.i_enable = 1'b0;
        @(negedge clk);
        chk("en_off_hex", {11'b0, bus.o_hex2, bus.o_hex1, bus.o_hex0}, {11'b0, pk(7'h7F, 7'h7F, 7'h7F)});
        repeat (4) @(negedge clk);
        bus.i_enable = 1'b1;
        @(negedge clk);
        chk("en_on_hex", {11'b0, bus.o_hex2, bus.o_hex1, bus.o_hex0}, {11'b0, pk(7'h7F, 7'h30, 7'h30)});
        repeat (2) @(negedge clk);

        // Reset in the middle of SHIFT aborts; value present at release is converted
        bus.i_value = 7'd88;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_hex", {11'b0, bus.o_hex2, bus.o_hex1, bus.o_hex0}, {11'b0, pk(7'h7F, 7'h7F, 7'h7F)});
        chk("midrst_busy", bus.o_busy, 0);
        bus.i_value = 7'd64;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive("v64", 7'd64, pk(7'h7F, 7'h02, 7'h19));
        bus.i_value = 7'd64;
        wait_done("v64");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seg7_random_display.md
Name: seg7_random_display

Overview:
- Downstream stage of the Lab1 random-number generator. It consumes the 7-bit random value (0..127) and drives three active-low seven-segment digits (HEX2..HEX0).
- Binary-to-BCD conversion is a sequential double-dabble, one bit per clock. A new conversion starts whenever the input differs from the last converted value.
- Displayed digits change only on conversion completion, so the display never shows partial results.

Parameters:
- BLANK_LZ, 1, 1 = blank leading-zero hundreds/tens digits; 0 = always show all three digits.
- IN_W, 7, input value width (fixed at 7; the BCD datapath is sized for 0..127).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset; asynchronous, active-high.
- i_value  input  IN_W  random value from generator (may change any cycle).
- i_enable  input  1  1 = display converted value; 0 = all digits blank.
- o_hex0  output  7  ones digit, active-low, bit6=g .. bit0=a.
- o_hex1  output  7  tens digit, same encoding.
- o_hex2  output  7  hundreds digit, same encoding.
- o_busy  output  1  high while a conversion is in progress.
- o_update  output  1  one-cycle pulse when new digits are latched.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; o_hex0/1/2=7'h7F (blank); o_busy=0; o_update=0.
  - The "have_value" flag is cleared, so the first post-reset cycle always starts a conversion.
- States: IDLE, SHIFT, LATCH.
- IDLE: start a conversion when have_value==0 or i_value != last_value.
  - On start: capture i_value into shift register and last_value; clear BCD accumulator (12 bits); count=0; go to SHIFT.
- SHIFT: runs exactly 7 cycles.
  - Each cycle, every BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1; count increments.
  - Leave to LATCH when count==6 completes.
- LATCH: one cycle.
  - Digit registers <= BCD nibbles; have_value<=1; o_update=1 this cycle; return to IDLE.
- Latency: i_value sampled in cycle N (IDLE); digits visible on outputs from cycle N+9 (7 SHIFT + 1 LATCH + registered output). Back-to-back changes: the next conversion can start in the IDLE cycle right after LATCH.
- o_busy = 1 in SHIFT and LATCH.
- Input changes while busy are ignored. On return to IDLE the compare against last_value restarts a conversion, so the display always converges to the final stable input.
- Hundreds nibble is only ever 0 or 1; tens and ones are 0..9.
- Output encoding (registered, active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- Leading-zero blanking (BLANK_LZ=1):
  - hex2 blank if hundreds==0.
  - hex1 blank if hundreds==0 and tens==0.
  - hex0 is never blanked by this rule.
- i_enable=0: all three outputs become 7F on the next clock. Conversion continues normally, and the stored digits reappear on the clock after i_enable returns to 1.
- Reset mid-conversion: the in-flight conversion is aborted immediately and outputs blank. After release, the current i_value is converted from scratch.

Decomposition:
- Package seg7_pkg:
  - state enum {IDLE, SHIFT, LATCH};
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - function bcd_to_seg(nibble).
- Sub-module bin2bcd_seq: contains the shift/add-3 datapath and the counter, with start/done handshake.
- Top: change detection, blanking, output registers.

Test Plan:
- Reset release with i_value=0, i_enable=1 -> o_update pulses at cycle 8; then hex0=40, hex1=7F, hex2=7F.
- i_value=57 held -> after 9 cycles hex2=7F, hex1=12, hex0=78; o_busy high for exactly 8 cycles.
- i_value=100 then 127 (BLANK_LZ=1) -> hex2/1/0 = 79/40/40, then 79/24/78; an intermediate zero tens digit is not blanked.
- i_value 42 -> 9 on cycle 3 of SHIFT -> first 42 shown (hex1=19, hex0=24), then automatic reconversion shows hex1=7F, hex0=10; exactly two o_update pulses.
- i_enable low for 5 cycles while showing 33 -> all outputs 7F next cycle; 30/30 restored one cycle after i_enable=1.
- Assert i_rst during SHIFT -> outputs 7F, o_busy=0 asynchronously; after release, current i_value is converted in 9 cycles.
